// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-signal pipeline: interlock states,
// default geometry and symbolic stage indices.
package ctrl_pkg;

    // Multi-cycle interlock states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Default geometry of the pipeline
    localparam int DEF_NSTAGE = 3;
    localparam int DEF_CTRL_W = 24;

    // Symbolic stage indices below decode
    localparam int EX = 0;
    localparam int ME = 1;
    localparam int WB = 2;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding a control bundle, its valid bit and
// the multi-cycle tag. Flush beats hold, hold beats bubble, bubble beats load.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_valid,
    input  logic              in_mc,
    output logic [CTRL_W-1:0] ctrl,
    output logic              valid,
    output logic              mc
);

    // Stage contents: clear on reset/flush/bubble, keep on hold, else load
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            ctrl  <= '0;
            valid <= 1'b0;
            mc    <= 1'b0;
        end else if (hold) begin
            ctrl  <= ctrl;
            valid <= valid;
            mc    <= mc;
        end else if (bubble) begin
            ctrl  <= '0;
            valid <= 1'b0;
            mc    <= 1'b0;
        end else begin
            ctrl  <= in_ctrl;
            valid <= in_valid;
            mc    <= in_mc;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-signal pipeline from decode through NSTAGE register stages, with a
// hold chain that inserts bubbles below a stuck stage and an interlock that
// keeps a divide resident in EX for DIV_CYCLES cycles.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int CTRL_W         = DEF_CTRL_W,
    parameter int NSTAGE         = DEF_NSTAGE,
    parameter int LAST_STALLABLE = 0,
    parameter int DIV_CYCLES     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        de_ctrl,
    input  logic                     de_valid,
    input  logic                     de_mc,
    input  logic [NSTAGE-1:0]        stall,
    input  logic [NSTAGE-1:0]        flush,
    output logic [NSTAGE*CTRL_W-1:0] stage_ctrl,
    output logic [NSTAGE-1:0]        stage_valid,
    output logic                     de_hold,
    output logic                     mc_busy,
    output logic                     mc_done
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

    logic [CTRL_W-1:0] sc [NSTAGE];
    logic [NSTAGE-1:0] sv;
    logic [NSTAGE-1:0] smc;
    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] bubble;

    mc_state_t         state;
    mc_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              stage0_mc;

    // The tag only matters in EX; downstream copies are tied off and unused
    logic unused_tags;
    assign unused_tags = ^smc;

    assign stage0_mc   = sv[EX] & smc[EX];
    assign mc_busy     = stage0_mc & (state != DONE);
    assign mc_done     = (state == DONE);
    assign de_hold     = hold[EX];
    assign stage_valid = sv;

    // Hold chain, walked from the last stage upward so each stage sees the one below
    always_comb begin
        logic below;
        logic own;
        hold  = '0;
        below = 1'b0;
        own   = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (k == NSTAGE - 1) begin
                own = (LAST_STALLABLE != 0) ? stall[k] : 1'b0;
            end else begin
                own = stall[k];
            end
            hold[k] = own | below | ((k == 0) && mc_busy);
            below   = hold[k];
        end
    end

    // A stage takes a bubble when the stage above is stuck but it is free to move
    always_comb begin
        bubble = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            bubble[k] = hold[k-1] & ~hold[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NSTAGE; g++) begin : g_stage
            logic [CTRL_W-1:0] src_ctrl;
            logic              src_valid;
            logic              src_mc;

            if (g == 0) begin : g_src_de
                assign src_ctrl  = de_ctrl;
                assign src_valid = de_valid;
                assign src_mc    = de_mc;
            end else begin : g_src_prev
                assign src_ctrl  = sc[g-1];
                assign src_valid = sv[g-1];
                assign src_mc    = 1'b0;
            end

            ctrl_stage_reg #(
                .CTRL_W (CTRL_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .hold     (hold[g]),
                .bubble   (bubble[g]),
                .flush    (flush[g]),
                .in_ctrl  (src_ctrl),
                .in_valid (src_valid),
                .in_mc    (src_mc),
                .ctrl     (sc[g]),
                .valid    (sv[g]),
                .mc       (smc[g])
            );

            assign stage_ctrl[g*CTRL_W +: CTRL_W] = sc[g];
        end
    endgenerate

    // Interlock state and countdown register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Interlock next state: start on a divide in EX, count down, wait for EX to turn over
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush[EX]) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stage0_mc) begin
                        state_next = RUN;
                        cnt_next   = CNT_INIT;
                    end
                end
                RUN: begin
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (!hold[EX]) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline with a short divide latency so every
// interlock phase can be walked by hand.
module tb_ctrl_pipeline;

    localparam int CTRL_W = 24;
    localparam int NSTAGE = 3;
    localparam int DIV    = 4;

    logic                     clk;
    logic                     rst;
    logic [CTRL_W-1:0]        de_ctrl;
    logic                     de_valid;
    logic                     de_mc;
    logic [NSTAGE-1:0]        stall;
    logic [NSTAGE-1:0]        flush;
    logic [NSTAGE*CTRL_W-1:0] stage_ctrl;
    logic [NSTAGE-1:0]        stage_valid;
    logic                     de_hold;
    logic                     mc_busy;
    logic                     mc_done;

    int checks = 0;
    int errors = 0;

    ctrl_pipeline #(
        .CTRL_W         (CTRL_W),
        .NSTAGE         (NSTAGE),
        .LAST_STALLABLE (0),
        .DIV_CYCLES     (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .de_ctrl     (de_ctrl),
        .de_valid    (de_valid),
        .de_mc       (de_mc),
        .stall       (stall),
        .flush       (flush),
        .stage_ctrl  (stage_ctrl),
        .stage_valid (stage_valid),
        .de_hold     (de_hold),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] sctrl(input int k);
        return stage_ctrl[k*CTRL_W +: CTRL_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        de_valid = 1'b0;
        de_mc    = 1'b0;
        de_ctrl  = '0;
        stall    = '0;
        flush    = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; de_ctrl = '0; de_valid = 1'b0; de_mc = 1'b0; stall = '0; flush = '0;
        repeat (2) tick();
        checks++; if (stage_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_valid got %b expected 000", stage_valid); end
        checks++; if (stage_ctrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl got %h expected 0", stage_ctrl); end
        checks++; if ({mc_busy, mc_done, de_hold} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 000", {mc_busy, mc_done, de_hold}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_free_flow();
        de_valid = 1'b1; de_ctrl = 24'h1; tick();
        de_ctrl = 24'h2; tick();
        de_ctrl = 24'h3; tick();
        checks++; if (sctrl(2) !== 24'h1) begin errors++; $display("[TB] FAIL flow_wb1 got %h expected 1", sctrl(2)); end
        checks++; if (stage_valid !== 3'b111) begin errors++; $display("[TB] FAIL flow_valid got %b expected 111", stage_valid); end
        de_valid = 1'b0; de_ctrl = '0; tick();
        checks++; if (sctrl(2) !== 24'h2) begin errors++; $display("[TB] FAIL flow_wb2 got %h expected 2", sctrl(2)); end
        tick();
        checks++; if (sctrl(2) !== 24'h3) begin errors++; $display("[TB] FAIL flow_wb3 got %h expected 3", sctrl(2)); end
        checks++; if (stage_valid !== 3'b100) begin errors++; $display("[TB] FAIL flow_tail_valid got %b expected 100", stage_valid); end
        drain();
    endtask

    task automatic test_stall_me();
        de_valid = 1'b1; de_ctrl = 24'hA; tick();
        de_ctrl = 24'hB; tick();
        de_ctrl = 24'hC; stall = 3'b010; #1;
        checks++; if (de_hold !== 1'b1) begin errors++; $display("[TB] FAIL stall_de_hold got %b expected 1", de_hold); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({sctrl(1), sctrl(0)} !== {24'hA, 24'hB}) begin errors++; $display("[TB] FAIL stall_hold%0d got %h/%h expected A/B", i, sctrl(1), sctrl(0)); end
            checks++; if (stage_valid[2] !== 1'b0 || sctrl(2) !== '0) begin errors++; $display("[TB] FAIL stall_wb_bubble%0d got v=%b c=%h expected v=0 c=0", i, stage_valid[2], sctrl(2)); end
        end
        stall = '0; #1;
        checks++; if (de_hold !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got %b expected 0", de_hold); end
        tick();
        checks++; if ({sctrl(2), sctrl(1), sctrl(0)} !== {24'hA, 24'hB, 24'hC} || stage_valid !== 3'b111) begin errors++; $display("[TB] FAIL stall_resume got %h/%h/%h v=%b expected A/B/C v=111", sctrl(2), sctrl(1), sctrl(0), stage_valid); end
        drain();
    endtask

    task automatic test_divide();
        de_valid = 1'b1; de_mc = 1'b1; de_ctrl = 24'h5; tick();
        de_mc = 1'b0; de_ctrl = 24'h6; #1;
        for (int i = 0; i < DIV; i++) begin
            checks++; if ({mc_busy, de_hold, mc_done} !== 3'b110) begin errors++; $display("[TB] FAIL div_busy%0d got busy/hold/done=%b expected 110", i, {mc_busy, de_hold, mc_done}); end
            tick();
            checks++; if (stage_valid[1] !== 1'b0) begin errors++; $display("[TB] FAIL div_me_bubble%0d got %b expected 0", i, stage_valid[1]); end
        end
        checks++; if ({mc_busy, de_hold, mc_done} !== 3'b001) begin errors++; $display("[TB] FAIL div_done got busy/hold/done=%b expected 001", {mc_busy, de_hold, mc_done}); end
        checks++; if (sctrl(0) !== 24'h5 || stage_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL div_ex_resident got %h v=%b expected 5 v=1", sctrl(0), stage_valid[0]); end
        tick();
        de_valid = 1'b0; de_ctrl = '0; #1;
        checks++; if ({sctrl(1), sctrl(0)} !== {24'h5, 24'h6} || stage_valid[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL div_leave got %h/%h v=%b expected 5/6 v=11", sctrl(1), sctrl(0), stage_valid[1:0]); end
        checks++; if ({mc_busy, mc_done} !== 2'b00) begin errors++; $display("[TB] FAIL div_idle got %b expected 00", {mc_busy, mc_done}); end
        drain();
    endtask

    task automatic test_flush_run();
        bit seen_done;
        de_valid = 1'b1; de_mc = 1'b1; de_ctrl = 24'h7; tick();
        de_valid = 1'b0; de_mc = 1'b0; de_ctrl = '0;
        repeat (2) tick();
        flush = 3'b001; #1;
        checks++; if (mc_busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_busy got %b expected 1", mc_busy); end
        tick();
        flush = '0; #1;
        checks++; if (stage_valid[0] !== 1'b0 || sctrl(0) !== '0) begin errors++; $display("[TB] FAIL flush_ex got v=%b c=%h expected v=0 c=0", stage_valid[0], sctrl(0)); end
        checks++; if ({mc_busy, de_hold} !== 2'b00) begin errors++; $display("[TB] FAIL flush_busy got %b expected 00", {mc_busy, de_hold}); end
        seen_done = mc_done;
        for (int i = 0; i < DIV + 2; i++) begin
            tick();
            seen_done = seen_done | mc_done;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done got %b expected 0", seen_done); end
        drain();
    endtask

    task automatic test_stall_flush();
        de_valid = 1'b1; de_ctrl = 24'h9; tick();
        de_ctrl = 24'hC; stall = 3'b001; flush = 3'b001; #1;
        checks++; if (de_hold !== 1'b1) begin errors++; $display("[TB] FAIL sf_de_hold got %b expected 1", de_hold); end
        tick();
        checks++; if (stage_valid[0] !== 1'b0 || sctrl(0) !== '0) begin errors++; $display("[TB] FAIL sf_ex got v=%b c=%h expected v=0 c=0", stage_valid[0], sctrl(0)); end
        stall = '0; flush = '0; tick();
        checks++; if (sctrl(0) !== 24'hC || stage_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL sf_next got %h v=%b expected C v=1", sctrl(0), stage_valid[0]); end
        drain();
    endtask

    task automatic test_back_to_back();
        de_valid = 1'b1; de_mc = 1'b1; de_ctrl = 24'h21; tick();
        de_ctrl = 24'h22;
        for (int i = 0; i < DIV; i++) begin
            checks++; if (mc_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_busy%0d got %b expected 1", i, mc_busy); end
            tick();
        end
        checks++; if ({mc_busy, mc_done} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_first_done got %b expected 01", {mc_busy, mc_done}); end
        tick();
        de_valid = 1'b0; de_mc = 1'b0; de_ctrl = '0; #1;
        checks++; if ({sctrl(1), sctrl(0)} !== {24'h21, 24'h22}) begin errors++; $display("[TB] FAIL b2b_swap got %h/%h expected 21/22", sctrl(1), sctrl(0)); end
        for (int i = 0; i < DIV; i++) begin
            checks++; if ({mc_busy, mc_done} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_second_busy%0d got %b expected 10", i, {mc_busy, mc_done}); end
            tick();
        end
        checks++; if ({mc_busy, mc_done} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_second_done got %b expected 01", {mc_busy, mc_done}); end
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        de_valid = 1'b1; de_ctrl = 24'h11; tick();
        de_ctrl = 24'h12; tick();
        de_ctrl = 24'h13; de_mc = 1'b1; tick();
        de_mc = 1'b0; de_ctrl = 24'h14; #1;
        checks++; if (stage_valid !== 3'b111 || mc_busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre got v=%b busy=%b expected v=111 busy=1", stage_valid, mc_busy); end
        rst = 1'b0; tick();
        checks++; if (stage_valid !== 3'b000 || stage_ctrl !== '0) begin errors++; $display("[TB] FAIL rm_clear got v=%b c=%h expected all 0", stage_valid, stage_ctrl); end
        checks++; if ({mc_busy, mc_done, de_hold} !== 3'b000) begin errors++; $display("[TB] FAIL rm_flags got %b expected 000", {mc_busy, mc_done, de_hold}); end
        rst = 1'b1; de_ctrl = 24'h15; tick();
        de_valid = 1'b0; de_ctrl = '0;
        seen_done = mc_done;
        checks++; if (sctrl(0) !== 24'h15 || de_hold !== 1'b0) begin errors++; $display("[TB] FAIL rm_new_ex got %h hold=%b expected 15 hold=0", sctrl(0), de_hold); end
        repeat (2) begin tick(); seen_done = seen_done | mc_done; end
        checks++; if (sctrl(2) !== 24'h15 || stage_valid !== 3'b100) begin errors++; $display("[TB] FAIL rm_new_wb got %h v=%b expected 15 v=100", sctrl(2), stage_valid); end
        repeat (DIV + 2) begin tick(); seen_done = seen_done | mc_done; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_done got %b expected 0", seen_done); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_free_flow();
        test_stall_me();
        test_divide();
        test_flush_run();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
